// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   DATA_W / ADDR_W : data and byte-address widths
//   state_e         : responder FSM states
//   access_err()    : misaligned or out-of-range access detection
package mips_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // An access is in error when it is not word aligned or its word index
  // falls beyond the implemented storage.
  function automatic logic access_err(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth);
    logic [ADDR_W-1:0] word_idx;
    word_idx = {2'b00, addr[ADDR_W-1:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder.
//   clk     : write clock
//   i_we    : commit i_wdata bytes selected by i_be to word i_idx
//   i_be    : byte enables, i_be[i] covers i_wdata[8i+7:8i]
//   i_idx   : word index shared by the write and read ports
//   i_wdata : store data
//   o_rdata : combinational read of word i_idx (registered by the parent)
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [DATA_W-1:0]              i_wdata,
  output logic [DATA_W-1:0]              o_rdata
);

  // Storage is deliberately not reset so contents survive rst.
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for a simple CPU bus.
//   clk, rst       : clock and asynchronous active-low reset
//   req            : request, held by the initiator until ack
//   we             : 1 = store, 0 = load
//   addr           : byte address, word index addr[31:2]
//   wdata, be      : store data and byte enables
//   ack            : one-cycle response strobe
//   rdata, err     : load data and error flag, valid only with ack
// The request is captured in IDLE, held for WAIT_CYCLES cycles in WAIT and
// answered in RESP; memory is written or read on the edge entering RESP.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        be,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_e            r_state, w_state_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_be;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_go_resp;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic [3:0]        w_acc_be;
  logic              w_acc_err;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_rdata;

  assign w_accept  = (r_state == IDLE) && req;
  assign w_go_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                     ((r_state == WAIT) && (r_cnt == 4'd0));

  // With zero wait cycles the access completes on the capture edge, so the
  // live inputs are used; otherwise the captured copies are.
  always_comb begin
    if (r_state == IDLE) begin
      w_acc_we    = we;
      w_acc_addr  = addr;
      w_acc_wdata = wdata;
      w_acc_be    = be;
    end else begin
      w_acc_we    = r_we;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      w_acc_be    = r_be;
    end
  end

  assign w_acc_err = access_err(w_acc_addr, DEPTH_WORDS);
  assign w_mem_we  = w_go_resp && w_acc_we && !w_acc_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .i_we   (w_mem_we),
    .i_be   (w_acc_be),
    .i_idx  (w_acc_addr[IDX_W+1:2]),
    .i_wdata(w_acc_wdata),
    .o_rdata(w_mem_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_accept) begin
      w_cnt_next = CNT_INIT;
    end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
      w_cnt_next = r_cnt - 4'd1;
    end
  end

  // Counter and response registers; err/rdata are only non-zero in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_err   <= w_go_resp && w_acc_err;
      r_rdata <= (w_go_resp && !w_acc_we && !w_acc_err) ? w_mem_rdata : '0;
    end
  end

  // Request capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 4'd0;
    end else if (w_accept) begin
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
      r_be    <= be;
    end
  end

  // Outputs.
  always_comb begin
    ack   = (r_state == RESP);
    err   = r_err;
    rdata = r_rdata;
  end

endmodule
